// File: rtl/mem_ctrl_pkg.sv
// Shared types and constants for the 16-bit memory initiator: FSM states,
// CPU access-size encodings and address widths.
package mem_ctrl_pkg;

  localparam int ADDR_WIDTH      = 12;
  localparam int BYTE_ADDR_WIDTH = 13;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_RD0  = 3'd1,
    S_RD1  = 3'd2,
    S_CAP  = 3'd3,
    S_MRG  = 3'd4,
    S_WR0  = 3'd5,
    S_WR1  = 3'd6,
    S_DONE = 3'd7
  } mc_state_t;

  // Misaligned halfword/word or the reserved size code are rejected up front.
  function automatic logic req_illegal(input logic [1:0] size, input logic addr_lsb);
    return (size == 2'b11) || ((size != SZ_BYTE) && addr_lsb);
  endfunction

endpackage

// File: rtl/mem_ctrl_merge.sv
// Byte-lane logic: replaces one byte of a memory halfword for byte stores and
// picks one byte out of it for byte loads (little-endian, odd byte in [15:8]).
module mem_ctrl_merge
  import mem_ctrl_pkg::*;
(
  input  logic [15:0] mem_word,
  input  logic        byte_sel,
  input  logic [7:0]  wr_byte,
  output logic [15:0] merged_word,
  output logic [7:0]  rd_byte
);

  always_comb begin
    merged_word = mem_word;
    rd_byte     = mem_word[7:0];
    if (byte_sel) begin
      merged_word[15:8] = wr_byte;
      rd_byte           = mem_word[15:8];
    end else begin
      merged_word[7:0]  = wr_byte;
      rd_byte           = mem_word[7:0];
    end
  end

endmodule

// File: rtl/mem_ctrl.sv
// CPU-facing load/store controller that maps byte/half/word requests onto a
// single-port 16-bit memory, with read-modify-write for byte stores.
module mem_ctrl
  import mem_ctrl_pkg::*;
(
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       CPU_MEMCTRL_req,
  input  logic                       CPU_MEMCTRL_we,
  input  logic [1:0]                 CPU_MEMCTRL_size,
  input  logic [BYTE_ADDR_WIDTH-1:0] CPU_MEMCTRL_addr,
  input  logic [31:0]                CPU_MEMCTRL_wdata,
  output logic [31:0]                MEMCTRL_CPU_rdata,
  output logic                       MEMCTRL_CPU_done,
  output logic                       MEMCTRL_CPU_err,
  output logic                       MEMCTRL_CPU_busy,
  input  logic [15:0]                MEM_MEMCTRL_from_mem_data,
  output logic                       MEMCTRL_MEM_to_mem_mem_enable,
  output logic                       MEMCTRL_MEM_to_mem_read_enable,
  output logic                       MEMCTRL_MEM_to_mem_write_enable,
  output logic [ADDR_WIDTH-1:0]      MEMCTRL_MEM_to_mem_address,
  output logic [15:0]                MEMCTRL_MEM_to_mem_data
);

  mc_state_t                  state_q, state_d;
  logic                       we_q, we_d;
  logic [1:0]                 size_q, size_d;
  logic [BYTE_ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [31:0]                wdata_q, wdata_d;
  logic                       err_q, err_d;
  logic [15:0]                lo_q, lo_d;
  logic [15:0]                merge_q, merge_d;
  logic [31:0]                rdata_q, rdata_d;

  logic [ADDR_WIDTH-1:0]      word_addr;
  logic [ADDR_WIDTH-1:0]      word_addr_hi;
  logic [15:0]                merged_word;
  logic [7:0]                 rd_byte;

  // High half of a word wraps modulo the memory depth.
  assign word_addr    = addr_q[BYTE_ADDR_WIDTH-1:1];
  assign word_addr_hi = word_addr + 12'd1;

  mem_ctrl_merge u_merge (
    .mem_word    (MEM_MEMCTRL_from_mem_data),
    .byte_sel    (addr_q[0]),
    .wr_byte     (wdata_q[7:0]),
    .merged_word (merged_word),
    .rd_byte     (rd_byte)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      we_q    <= 1'b0;
      size_q  <= 2'b00;
      addr_q  <= '0;
      wdata_q <= 32'h0;
      err_q   <= 1'b0;
      lo_q    <= 16'h0;
      merge_q <= 16'h0;
      rdata_q <= 32'h0;
    end else begin
      state_q <= state_d;
      we_q    <= we_d;
      size_q  <= size_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      err_q   <= err_d;
      lo_q    <= lo_d;
      merge_q <= merge_d;
      rdata_q <= rdata_d;
    end
  end

  always_comb begin
    state_d = state_q;
    we_d    = we_q;
    size_d  = size_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    err_d   = err_q;
    lo_d    = lo_q;
    merge_d = merge_q;
    rdata_d = rdata_q;
    case (state_q)
      S_IDLE: begin
        if (CPU_MEMCTRL_req) begin
          we_d    = CPU_MEMCTRL_we;
          size_d  = CPU_MEMCTRL_size;
          addr_d  = CPU_MEMCTRL_addr;
          wdata_d = CPU_MEMCTRL_wdata;
          err_d   = req_illegal(CPU_MEMCTRL_size, CPU_MEMCTRL_addr[0]);
          if (req_illegal(CPU_MEMCTRL_size, CPU_MEMCTRL_addr[0])) begin
            state_d = S_DONE;
          end else if (CPU_MEMCTRL_we && (CPU_MEMCTRL_size != SZ_BYTE)) begin
            state_d = S_WR0;
          end else begin
            state_d = S_RD0;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_RD0: begin
        if (size_q == SZ_WORD) begin
          state_d = S_RD1;
        end else if (we_q) begin
          state_d = S_MRG;
        end else begin
          state_d = S_CAP;
        end
      end
      S_RD1: begin
        lo_d    = MEM_MEMCTRL_from_mem_data;
        state_d = S_CAP;
      end
      S_CAP: begin
        case (size_q)
          SZ_BYTE: rdata_d = {24'h0, rd_byte};
          SZ_HALF: rdata_d = {16'h0, MEM_MEMCTRL_from_mem_data};
          SZ_WORD: rdata_d = {MEM_MEMCTRL_from_mem_data, lo_q};
          default: rdata_d = rdata_q;
        endcase
        state_d = S_DONE;
      end
      S_MRG: begin
        merge_d = merged_word;
        state_d = S_WR0;
      end
      S_WR0: begin
        if (size_q == SZ_WORD) begin
          state_d = S_WR1;
        end else begin
          state_d = S_DONE;
        end
      end
      S_WR1:   state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Memory strobes are a pure decode of the state register, so reset drops them at once.
  always_comb begin
    MEMCTRL_MEM_to_mem_mem_enable   = 1'b0;
    MEMCTRL_MEM_to_mem_read_enable  = 1'b0;
    MEMCTRL_MEM_to_mem_write_enable = 1'b0;
    MEMCTRL_MEM_to_mem_address      = 12'h0;
    MEMCTRL_MEM_to_mem_data         = 16'h0;
    case (state_q)
      S_RD0: begin
        MEMCTRL_MEM_to_mem_mem_enable  = 1'b1;
        MEMCTRL_MEM_to_mem_read_enable = 1'b1;
        MEMCTRL_MEM_to_mem_address     = word_addr;
      end
      S_RD1: begin
        MEMCTRL_MEM_to_mem_mem_enable  = 1'b1;
        MEMCTRL_MEM_to_mem_read_enable = 1'b1;
        MEMCTRL_MEM_to_mem_address     = word_addr_hi;
      end
      S_WR0: begin
        MEMCTRL_MEM_to_mem_mem_enable   = 1'b1;
        MEMCTRL_MEM_to_mem_write_enable = 1'b1;
        MEMCTRL_MEM_to_mem_address      = word_addr;
        MEMCTRL_MEM_to_mem_data         = (size_q == SZ_BYTE) ? merge_q : wdata_q[15:0];
      end
      S_WR1: begin
        MEMCTRL_MEM_to_mem_mem_enable   = 1'b1;
        MEMCTRL_MEM_to_mem_write_enable = 1'b1;
        MEMCTRL_MEM_to_mem_address      = word_addr_hi;
        MEMCTRL_MEM_to_mem_data         = wdata_q[31:16];
      end
      default: begin
        MEMCTRL_MEM_to_mem_mem_enable   = 1'b0;
      end
    endcase
  end

  assign MEMCTRL_CPU_done  = (state_q == S_DONE);
  assign MEMCTRL_CPU_err   = (state_q == S_DONE) && err_q;
  assign MEMCTRL_CPU_busy  = (state_q != S_IDLE);
  assign MEMCTRL_CPU_rdata = rdata_q;

endmodule
